// File: rtl/inv_round_tail.sv
// inv_round_tail -- decryption-side AES-128 round tail.
//
// Takes a 128-bit state that has already been through InvSubBytes and
// applies InvShiftRows, AddRoundKey and (unless last_round) InvMixColumns.
//
// Byte k = 4*c + r (column c, row r) lives in bits [8k+7:8k] of every
// 128-bit bus.
//
// Build option (macro INV_ROUND_PIPE2_EN):
//   defined   : two registered stages, 2-cycle latency. S1 holds the
//               shifted+keyed state, S2 holds the InvMixColumns/bypass result.
//   undefined : whole function computed combinationally into one output
//               register, 1-cycle latency.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input beat present
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   state_isb  in   [127:0] state after InvSubBytes
//   round_key  in   [127:0] round key, captured with the beat
//   last_round in   1 = final round, InvMixColumns skipped
//   out_valid  out  result present
//   out_ready  in   downstream takes the result this cycle
//   state_out  out  [127:0] round result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that
// edge; out_valid never drops without a transfer except on reset. in_ready
// is combinational in out_ready so a full pipe can accept and drain in the
// same cycle.

module inv_round_tail (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_isb,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // out[r][c] = in[r][(c - r) mod 4]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    inv_shift_rows = o;
  endfunction

  // Coefficients 09/0b/0d/0e built from x2, x4, x8 of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    inv_mix_col = o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    end
    inv_mix_columns = o;
  endfunction

  logic         accept;
  logic [127:0] keyed;

  assign accept = in_valid & in_ready;
  assign keyed  = inv_shift_rows(state_isb) ^ round_key;

`ifdef INV_ROUND_PIPE2_EN

  logic         s1_valid_q, s1_valid_d;
  logic [127:0] s1_data_q,  s1_data_d;
  logic         s1_last_q,  s1_last_d;
  logic         s2_valid_q, s2_valid_d;
  logic [127:0] s2_data_q,  s2_data_d;
  logic         s2_load;

  // S1 moves into S2 when S2 is empty or is draining this cycle.
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = keyed;
      s1_last_d  = last_round;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_last_q ? s1_data_q : inv_mix_columns(s1_data_q);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign state_out = s2_data_q;

`else

  logic         o_valid_q, o_valid_d;
  logic [127:0] o_data_q,  o_data_d;

  assign in_ready = ~o_valid_q | out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    if (accept) begin
      o_valid_d = 1'b1;
      o_data_d  = last_round ? keyed : inv_mix_columns(keyed);
    end else if (out_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign out_valid = o_valid_q;
  assign state_out = o_data_q;

`endif

endmodule

// File: tb/tb_inv_round_tail.sv
module tb_inv_round_tail;

`ifdef INV_ROUND_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  // Beats accepted before in_ready drops when the output is stalled.
  localparam int CAP = LAT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_isb = '0;
  logic [127:0] round_key = '0;
  logic         last_round = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  inv_round_tail dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_isb (state_isb),
    .round_key (round_key),
    .last_round(last_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                              input logic last);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] coef [4];
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = st[8*(4*c+r) +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r][c] = s[r][(c - r + 4) % 4] ^ key[8*(4*c+r) +: 8];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] v;
        if (last) v = t[r][c];
        else begin
          v = 8'h00;
          for (int j = 0; j < 4; j++) v = v ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
        end
        o[8*(4*c+r) +: 8] = v;
      end
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, expected no output", state_out);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (state_out !== e) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", state_out, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_round(state_isb, round_key, last_round));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [127:0] st, input logic [127:0] key, input logic last,
                            output bit ok);
    int n = 0;
    state_isb = st; round_key = key; last_round = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid (bounded).
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic drain_q();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(3);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (state_out !== '0) begin errors++; $display("FAIL reset_state_out: got %h, expected 0", state_out); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_inv_shift_rows();
    bit ok; int n;
    out_ready = 1'b1;
    drive_beat(128'h0f0e0d0c0b0a09080706050403020100, '0, 1'b1, ok);
    wait_out(n);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL isr_accept: got not-accepted, expected accepted"); end
    if (n !== LAT) begin errors++; $display("FAIL isr_latency: got %0d, expected %0d", n, LAT); end
    if (state_out !== 128'h0306090c0f0205080b0e0104070a0d00) begin
      errors++; $display("FAIL isr_data: got %h, expected 0306090c0f0205080b0e0104070a0d00", state_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inv_mix_columns();
    bit ok; int n;
    out_ready = 1'b1;
    drive_beat(128'hbca14d8e_bca14d8e_bca14d8e_bca14d8e, '0, 1'b0, ok);
    wait_out(n);
    checks += 2;
    if (n !== LAT) begin errors++; $display("FAIL imc_latency: got %0d, expected %0d", n, LAT); end
    if (state_out !== 128'h455313db_455313db_455313db_455313db) begin
      errors++; $display("FAIL imc_data: got %h, expected 455313db x4", state_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_round_key();
    bit ok; int n;
    out_ready = 1'b1;
    drive_beat(128'h0f0e0d0c0b0a09080706050403020100, {128{1'b1}}, 1'b1, ok);
    wait_out(n);
    checks += 2;
    if (n !== LAT) begin errors++; $display("FAIL ark_latency: got %0d, expected %0d", n, LAT); end
    if (state_out !== 128'hfcf9f6f3f0fdfaf7f4f1fefbf8f5f2ff) begin
      errors++; $display("FAIL ark_data: got %h, expected fcf9f6f3f0fdfaf7f4f1fefbf8f5f2ff", state_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] st [6];
    logic [127:0] hold = '0;
    bit have_hold = 0;
    int sent = 0;
    for (int i = 0; i < 6; i++) st[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 60 && (sent < 6 || exp_q.size() != 0); cyc++) begin
      out_ready  = (cyc >= 5);
      in_valid   = (sent < 6);
      state_isb  = st[sent % 6];
      round_key  = {4{32'h1111_0000 + 32'(sent)}};
      last_round = sent[0];
      @(negedge clk);
      if (cyc == 4) begin
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
        if (sent !== CAP) begin errors++; $display("FAIL bp_accepted: got %0d, expected %0d", sent, CAP); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", out_valid); end
      end
      if (cyc >= 2 && cyc <= 5 && out_valid) begin
        if (have_hold) begin
          checks++;
          if (state_out !== hold) begin errors++; $display("FAIL bp_stall_stable: got %h, expected %h", state_out, hold); end
        end
        hold = state_out; have_hold = 1;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (sent !== 6) begin errors++; $display("FAIL bp_sent: got %0d, expected 6", sent); end
    drain_q();
  endtask

  task automatic test_reset_midflight();
    bit ok; int n; int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; state_isb = {$urandom, $urandom, $urandom, $urandom};
      round_key = '1; last_round = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmf_in_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rmf_ghost: got %0d out_valid cycles, expected 0", seen); end
    drive_beat(128'hbca14d8e_bca14d8e_bca14d8e_bca14d8e, '0, 1'b0, ok);
    wait_out(n);
    checks += 2;
    if (n !== LAT) begin errors++; $display("FAIL rmf_latency: got %0d, expected %0d", n, LAT); end
    if (state_out !== 128'h455313db_455313db_455313db_455313db) begin
      errors++; $display("FAIL rmf_data: got %h, expected 455313db x4", state_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      state_isb  = {$urandom, $urandom, $urandom, $urandom};
      round_key  = {$urandom, $urandom, $urandom, $urandom};
      last_round = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    drain_q();
  endtask

  initial begin
    test_reset();
    test_inv_shift_rows();
    test_inv_mix_columns();
    test_add_round_key();
    test_backpressure();
    test_reset_midflight();
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
